// File: rtl/sdio_data_rx_crc.sv
// SDIO 4-bit data-line receiver: start-bit detect, nibble-to-byte deserialise,
// per-lane CRC16 check against the received CRC, end-bit check and status report.
module sdio_data_rx_crc #(
  parameter logic [15:0] POLYNOMIAL = 16'h1021,
  parameter logic [15:0] SEED       = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic [11:0] block_size,
  input  logic [3:0]  sd_dat,
  output logic [7:0]  data_byte,
  output logic        data_stb,
  output logic        busy,
  output logic        done,
  output logic        crc_ok,
  output logic [3:0]  crc_err_lanes,
  output logic        end_err
);

  typedef enum logic [2:0] {
    StIdle,
    StWaitStart,
    StData,
    StCrc,
    StEnd,
    StReport
  } state_e;

  state_e            state_q, state_d;
  logic              en_prev_q;
  logic [12:0]       nib_last_q, nib_last_d;
  logic [12:0]       nib_cnt_q, nib_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [3:0]        hi_q, hi_d;
  logic [7:0]        data_byte_q, data_byte_d;
  logic              data_stb_q, data_stb_d;
  logic              busy_q, busy_d;
  logic              crc_ok_q, crc_ok_d;
  logic [3:0]        crc_err_q, crc_err_d;
  logic              end_err_q, end_err_d;
  logic [3:0][15:0]  calc_q, calc_d;
  logic [3:0][15:0]  rx_q, rx_d;
  logic [3:0]        lane_mis;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic bit_in);
    logic inv;
    inv = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (inv ? POLYNOMIAL : 16'h0000);
  endfunction

  always_comb begin
    lane_mis = '0;
    for (int i = 0; i < 4; i++) begin
      lane_mis[i] = (calc_q[i] != rx_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    nib_last_d  = nib_last_q;
    nib_cnt_d   = nib_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    hi_d        = hi_q;
    data_byte_d = data_byte_q;
    data_stb_d  = 1'b0;
    busy_d      = busy_q;
    crc_ok_d    = crc_ok_q;
    crc_err_d   = crc_err_q;
    end_err_d   = end_err_q;
    calc_d      = calc_q;
    rx_d        = rx_q;

    if (state_q != StIdle && !en) begin
      // Abort: status stays as cleared at arm, no done, no more strobes.
      state_d = StIdle;
      busy_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (en && !en_prev_q) begin
            // Last nibble index is 2N-1; block_size 0 wraps to 0x1FFF (N = 4096).
            nib_last_d = {block_size - 12'd1, 1'b1};
            nib_cnt_d  = '0;
            crc_ok_d   = 1'b0;
            crc_err_d  = '0;
            end_err_d  = 1'b0;
            calc_d     = {4{SEED}};
            busy_d     = 1'b1;
            state_d    = StWaitStart;
          end
        end
        StWaitStart: begin
          if (sd_dat == 4'b0000) begin
            nib_cnt_d = '0;
            state_d   = StData;
          end
        end
        StData: begin
          for (int i = 0; i < 4; i++) begin
            calc_d[i] = crc_step(calc_q[i], sd_dat[i]);
          end
          if (!nib_cnt_q[0]) begin
            hi_d = sd_dat;
          end else begin
            data_byte_d = {hi_q, sd_dat};
            data_stb_d  = 1'b1;
          end
          nib_cnt_d = nib_cnt_q + 13'd1;
          if (nib_cnt_q == nib_last_q) begin
            bit_cnt_d = '0;
            state_d   = StCrc;
          end
        end
        StCrc: begin
          for (int i = 0; i < 4; i++) begin
            rx_d[i] = {rx_q[i][14:0], sd_dat[i]};
          end
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd15) begin
            state_d = StEnd;
          end
        end
        StEnd: begin
          // Status is latched here so it is already valid while done is high.
          end_err_d = (sd_dat != 4'b1111);
          crc_err_d = lane_mis;
          crc_ok_d  = ~|lane_mis & (sd_dat == 4'b1111);
          busy_d    = 1'b0;
          state_d   = StReport;
        end
        StReport: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      en_prev_q   <= 1'b0;
      nib_last_q  <= '0;
      nib_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      hi_q        <= '0;
      data_byte_q <= '0;
      data_stb_q  <= 1'b0;
      busy_q      <= 1'b0;
      crc_ok_q    <= 1'b0;
      crc_err_q   <= '0;
      end_err_q   <= 1'b0;
      calc_q      <= {4{SEED}};
      rx_q        <= '0;
    end else begin
      state_q     <= state_d;
      en_prev_q   <= en;
      nib_last_q  <= nib_last_d;
      nib_cnt_q   <= nib_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      hi_q        <= hi_d;
      data_byte_q <= data_byte_d;
      data_stb_q  <= data_stb_d;
      busy_q      <= busy_d;
      crc_ok_q    <= crc_ok_d;
      crc_err_q   <= crc_err_d;
      end_err_q   <= end_err_d;
      calc_q      <= calc_d;
      rx_q        <= rx_d;
    end
  end

  assign data_byte     = data_byte_q;
  assign data_stb      = data_stb_q;
  assign busy          = busy_q;
  assign done          = (state_q == StReport);
  assign crc_ok        = crc_ok_q;
  assign crc_err_lanes = crc_err_q;
  assign end_err       = end_err_q;

endmodule
